rf_scoreboard: RTL and testbench

Parametrised register file with a per-register pending-write scoreboard and optional same-cycle write-to-read bypass, for the pipelined CPU core. Two combinational read ports and one write-back port serve the datapath. The issue port reserves destination registers so the decode stage can stall on RAW hazards. This replaces the fixed 4x16 register file in the cache CPU.

---
 rtl/rf_scoreboard_if.sv | 30 +++
 rtl/rf_scoreboard.sv | 96 +++++++++
 tb/tb_rf_scoreboard.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_scoreboard_if.sv
// Register-file scoreboard bus: two read ports, one issue (reservation) port
// and one write-back port. master = datapath, slave = register file.
interface rf_scoreboard_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 2
) ();
  logic [ADDR_W-1:0]    addr1;
  logic [ADDR_W-1:0]    addr2;
  logic [WORD_SIZE-1:0] data1;
  logic [WORD_SIZE-1:0] data2;
  logic                 busy1;
  logic                 busy2;
  logic                 issue;
  logic [ADDR_W-1:0]    issue_addr;
  logic                 issue_ok;
  logic                 write;
  logic [ADDR_W-1:0]    addr3;
  logic [WORD_SIZE-1:0] data3;
  logic                 err;

  modport master (
    output addr1, addr2, issue, issue_addr, write, addr3, data3,
    input  data1, data2, busy1, busy2, issue_ok, err
  );

  modport slave (
    input  addr1, addr2, issue, issue_addr, write, addr3, data3,
    output data1, data2, busy1, busy2, issue_ok, err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register file with per-register pending-write counters. Decode reserves a
// destination through the issue port and stalls on busy; write-back retires
// one reservation. Optional same-cycle write-to-read forwarding and an
// optional hard-wired zero register.
module rf_scoreboard #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REG   = 4,
  parameter int ADDR_W    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 0,
  parameter int MAX_PEND  = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  rf_scoreboard_if.slave bus
);

  // Counters are 2 bits wide, so MAX_PEND is at most 3.
  localparam logic [1:0] MAX_PEND_C = 2'(MAX_PEND);

  logic [WORD_SIZE-1:0] regs [NUM_REG];
  logic [1:0]           pend [NUM_REG];
  logic                 err_q;

  logic byp1, byp2;
  logic zero1, zero2, zero_iss, zero_wr;
  logic issue_ok_w;
  logic inc_en;
  logic wr_en;

  // A reg-0 access is special only when the zero register is enabled.
  assign zero1    = (ZERO_REG != 0) && (bus.addr1 == '0);
  assign zero2    = (ZERO_REG != 0) && (bus.addr2 == '0);
  assign zero_iss = (ZERO_REG != 0) && (bus.issue_addr == '0);
  assign zero_wr  = (ZERO_REG != 0) && (bus.addr3 == '0);

  assign byp1 = (BYPASS != 0) && bus.write && (bus.addr3 == bus.addr1);
  assign byp2 = (BYPASS != 0) && bus.write && (bus.addr3 == bus.addr2);

  assign bus.data1 = zero1 ? '0 : (byp1 ? bus.data3 : regs[bus.addr1]);
  assign bus.data2 = zero2 ? '0 : (byp2 ? bus.data3 : regs[bus.addr2]);

  // A register whose last outstanding write lands this cycle is not busy
  // when that write is being forwarded.
  assign bus.busy1 = !zero1 && (pend[bus.addr1] != 2'd0) &&
                     !(byp1 && (pend[bus.addr1] == 2'd1));
  assign bus.busy2 = !zero2 && (pend[bus.addr2] != 2'd0) &&
                     !(byp2 && (pend[bus.addr2] == 2'd1));

  // Issue acceptance depends only on the counter, never on the write port,
  // so the decode stall path stays short.
  assign issue_ok_w   = bus.issue && (zero_iss || (pend[bus.issue_addr] < MAX_PEND_C));
  assign bus.issue_ok = issue_ok_w;
  assign inc_en       = issue_ok_w && !zero_iss;

  // Writes to the zero register are dropped entirely (no data, no error).
  assign wr_en   = bus.write && !zero_wr;
  assign bus.err = err_q;

  // Register data: write-back updates the addressed register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REG; r++) regs[r] <= '0;
    end else if (wr_en) begin
      regs[bus.addr3] <= bus.data3;
    end
  end

  // Pending counters: +1 on accepted issue, -1 on write-back, hold on both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REG; r++) pend[r] <= 2'd0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) begin
        logic inc, dec;
        inc = inc_en && (bus.issue_addr == ADDR_W'(r));
        dec = wr_en && (bus.addr3 == ADDR_W'(r)) && (pend[r] != 2'd0);
        case ({inc, dec})
          2'b10:   pend[r] <= pend[r] + 2'd1;
          2'b01:   pend[r] <= pend[r] - 2'd1;
          default: pend[r] <= pend[r];
        endcase
      end
    end
  end

  // Sticky error: a write-back with no reservation outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (wr_en && (pend[bus.addr3] == 2'd0)) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: a default instance (bypass on, no zero
// register) and a zero-register instance, with hand-computed expectations.
module tb_rf_scoreboard;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  rf_scoreboard_if #(.WORD_SIZE(16), .ADDR_W(2)) bus ();
  rf_scoreboard_if #(.WORD_SIZE(16), .ADDR_W(2)) zbus ();

  rf_scoreboard #(.WORD_SIZE(16), .NUM_REG(4), .ADDR_W(2), .BYPASS(1),
                  .ZERO_REG(0), .MAX_PEND(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));

  rf_scoreboard #(.WORD_SIZE(16), .NUM_REG(4), .ADDR_W(2), .BYPASS(1),
                  .ZERO_REG(1), .MAX_PEND(3)) dut_z (
    .clk(clk), .reset_n(reset_n), .bus(zbus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it misses.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge; inputs are then set and
  // outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue = 0; bus.issue_addr = 0; bus.write = 0; bus.addr3 = 0; bus.data3 = 0;
  endtask

  task automatic zidle();
    zbus.issue = 0; zbus.issue_addr = 0; zbus.write = 0; zbus.addr3 = 0; zbus.data3 = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    zidle();
    bus.addr1 = 0; bus.addr2 = 0;
    zbus.addr1 = 0; zbus.addr2 = 0;

    // Reset state, outputs with no clock edge.
    reset_n = 1'b0;
    #2;
    bus.addr1 = 2; bus.issue = 1; bus.issue_addr = 1;
    #1;
    check("rst_data1", bus.data1, 16'h0000);
    check("rst_busy1", bus.busy1, 1'b0);
    check("rst_issue_ok", bus.issue_ok, 1'b1);
    check("rst_err", bus.err, 1'b0);
    idle();
    #1;
    check("rst_issue_ok_idle", bus.issue_ok, 1'b0);
    tick();
    reset_n = 1'b1;

    // Reserve reg2 then reg1.
    tick();
    bus.issue = 1; bus.issue_addr = 2; bus.addr1 = 2;
    #1;
    check("iss2_ok", bus.issue_ok, 1'b1);
    check("iss2_busy_before", bus.busy1, 1'b0);
    tick();
    bus.issue_addr = 1;
    #1;
    check("reg2_busy", bus.busy1, 1'b1);
    check("iss1_ok", bus.issue_ok, 1'b1);

    // Write-back reg2 = 0x1234, forwarded in the same cycle.
    tick();
    idle();
    bus.write = 1; bus.addr3 = 2; bus.data3 = 16'h1234; bus.addr1 = 2; bus.addr2 = 1;
    #1;
    check("wb2_bypass_data", bus.data1, 16'h1234);
    check("wb2_bypass_busy", bus.busy1, 1'b0);
    check("reg1_busy", bus.busy2, 1'b1);

    // reg2 visible on plain path; reg1 = 0xBEEF forwarded with busy cleared.
    tick();
    bus.addr3 = 1; bus.data3 = 16'hBEEF;
    #1;
    check("reg2_plain", bus.data1, 16'h1234);
    check("reg2_free", bus.busy1, 1'b0);
    check("wb1_bypass_data", bus.data2, 16'hBEEF);
    check("wb1_bypass_busy", bus.busy2, 1'b0);
    check("no_err_yet", bus.err, 1'b0);

    // Fill reg3 to MAX_PEND, fourth issue rejected.
    tick();
    idle();
    bus.addr1 = 3;
    bus.issue = 1; bus.issue_addr = 3;
    #1;
    check("reg1_plain", bus.data2, 16'hBEEF);
    check("r3_iss1", bus.issue_ok, 1'b1);
    tick();
    #1;
    check("r3_iss2", bus.issue_ok, 1'b1);
    check("r3_busy", bus.busy1, 1'b1);
    tick();
    #1;
    check("r3_iss3", bus.issue_ok, 1'b1);
    tick();
    #1;
    check("r3_iss4_reject", bus.issue_ok, 1'b0);
    tick();
    #1;
    check("r3_iss5_reject", bus.issue_ok, 1'b0);

    // Three write-backs drain reg3; busy drops in the third write cycle.
    tick();
    idle();
    bus.write = 1; bus.addr3 = 3; bus.data3 = 16'h0001;
    #1;
    check("r3_wb1_busy", bus.busy1, 1'b1);
    tick();
    bus.data3 = 16'h0002;
    #1;
    check("r3_wb2_busy", bus.busy1, 1'b1);
    tick();
    bus.data3 = 16'h0003;
    #1;
    check("r3_wb3_busy", bus.busy1, 1'b0);
    check("r3_wb3_data", bus.data1, 16'h0003);
    tick();
    idle();
    #1;
    check("r3_after_busy", bus.busy1, 1'b0);
    check("r3_after_data", bus.data1, 16'h0003);
    check("r3_no_err", bus.err, 1'b0);

    // Simultaneous issue and write on reg1 with pend=1 leaves pend at 1.
    bus.issue = 1; bus.issue_addr = 1; bus.addr1 = 1;
    tick();
    bus.write = 1; bus.addr3 = 1; bus.data3 = 16'h5555;
    #1;
    check("r1_both_issue_ok", bus.issue_ok, 1'b1);
    check("r1_both_busy", bus.busy1, 1'b0);
    tick();
    idle();
    #1;
    check("r1_hold_busy", bus.busy1, 1'b1);
    check("r1_hold_data", bus.data1, 16'h5555);
    bus.write = 1; bus.addr3 = 1; bus.data3 = 16'h6666;
    tick();
    idle();
    #1;
    check("r1_drained", bus.busy1, 1'b0);
    check("r1_err_clear", bus.err, 1'b0);

    // Unreserved write to reg0 sets the sticky error.
    bus.write = 1; bus.addr3 = 0; bus.data3 = 16'h0077; bus.addr1 = 0;
    #1;
    check("err_same_cycle", bus.err, 1'b0);
    tick();
    idle();
    #1;
    check("err_set", bus.err, 1'b1);
    check("r0_written", bus.data1, 16'h0077);
    bus.issue = 1; bus.issue_addr = 0;
    tick();
    idle();
    bus.write = 1; bus.addr3 = 0; bus.data3 = 16'h0088;
    tick();
    idle();
    #1;
    check("err_sticky", bus.err, 1'b1);
    check("r0_valid_wb", bus.data1, 16'h0088);

    // Build pend[2]=2, regs[2]=0x00AA, then reset between edges.
    bus.issue = 1; bus.issue_addr = 2; bus.addr1 = 2;
    tick();
    tick();
    tick();
    idle();
    bus.write = 1; bus.addr3 = 2; bus.data3 = 16'h00AA;
    tick();
    idle();
    #1;
    check("pre_rst_data", bus.data1, 16'h00AA);
    check("pre_rst_busy", bus.busy1, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_data", bus.data1, 16'h0000);
    check("mid_rst_busy", bus.busy1, 1'b0);
    check("mid_rst_err", bus.err, 1'b0);
    #1;
    reset_n = 1'b1;
    tick();
    #1;
    check("post_rst_busy", bus.busy1, 1'b0);
    check("post_rst_data", bus.data1, 16'h0000);

    // Zero-register instance.
    zbus.addr1 = 0;
    zbus.write = 1; zbus.addr3 = 0; zbus.data3 = 16'hFFFF;
    #1;
    check("z_wb_data", zbus.data1, 16'h0000);
    check("z_wb_busy", zbus.busy1, 1'b0);
    tick();
    zidle();
    zbus.issue = 1; zbus.issue_addr = 0;
    #1;
    check("z_iss_ok", zbus.issue_ok, 1'b1);
    check("z_data", zbus.data1, 16'h0000);
    check("z_busy", zbus.busy1, 1'b0);
    check("z_err", zbus.err, 1'b0);
    tick();
    tick();
    tick();
    #1;
    check("z_iss_ok_repeat", zbus.issue_ok, 1'b1);
    check("z_busy_after", zbus.busy1, 1'b0);
    check("z_err_after", zbus.err, 1'b0);
    zidle();
    zbus.issue = 1; zbus.issue_addr = 1; zbus.addr2 = 1;
    tick();
    zidle();
    #1;
    check("z_r1_busy", zbus.busy2, 1'b1);
    zbus.write = 1; zbus.addr3 = 1; zbus.data3 = 16'h00C3;
    tick();
    zidle();
    #1;
    check("z_r1_data", zbus.data2, 16'h00C3);
    check("z_r1_free", zbus.busy2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
